// File: rtl/grid_mem_lines.sv
// grid_mem_lines: playfield row RAM with zero-fill after reset and a line-clear compaction engine
module grid_mem_lines #(
  parameter int COLS   = 10,
  parameter int ROWS   = 24,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [COLS-1:0]   data_a,
  input  logic              we_a,
  output logic [COLS-1:0]   q_a,
  input  logic [ADDR_W-1:0] addr_b,
  output logic [COLS-1:0]   q_b,
  input  logic              clr_start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   lines_cleared
);
  localparam int PW = ADDR_W + 1;
  localparam logic [PW-1:0] TOP  = PW'(ROWS);
  localparam logic [PW-1:0] LAST = PW'(ROWS - 1);

  typedef enum logic [2:0] {INIT, IDLE, SCAN, FILL, DONE} state_t;

  state_t              state_q, state_d;
  logic [PW-1:0]       rd_q, rd_d, wr_q, wr_d, lc_q, lc_d;
  logic [COLS-1:0]     q_a_q, q_a_d, q_b_q, q_b_d;
  logic                busy_q, busy_d, done_q, done_d;
  logic [COLS-1:0]     mem [ROWS];
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_wa;
  logic [COLS-1:0]     mem_wd;
  logic                a_ok, b_ok;

  assign a_ok = {1'b0, addr_a} < TOP;
  assign b_ok = {1'b0, addr_b} < TOP;

  // The engine reuses the port B read register as its scan pipeline stage.
  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    lc_d    = lc_q;
    q_a_d   = q_a_q;
    q_b_d   = q_b_q;
    mem_we  = 1'b0;
    mem_wa  = wr_q[ADDR_W-1:0];
    mem_wd  = '0;
    case (state_q)
      INIT: begin
        mem_we  = 1'b1;
        mem_wa  = rd_q[ADDR_W-1:0];
        rd_d    = rd_q + 1'b1;
        state_d = (rd_q == LAST) ? IDLE : INIT;
      end
      IDLE, DONE: begin
        mem_we  = we_a && a_ok;
        mem_wa  = addr_a;
        mem_wd  = data_a;
        q_a_d   = !a_ok ? '0 : we_a ? data_a : mem[addr_a];
        q_b_d   = b_ok ? mem[addr_b] : '0;
        state_d = IDLE;
        if (state_q == IDLE && clr_start) begin
          state_d = SCAN;
          rd_d    = '0;
          wr_d    = '0;
          lc_d    = '0;
        end
      end
      SCAN: begin
        rd_d = rd_q + 1'b1;
        if (rd_q < TOP) q_b_d = mem[rd_q[ADDR_W-1:0]];
        if (rd_q != '0) begin
          if (&q_b_q) lc_d = lc_q + 1'b1;
          else begin
            mem_we = 1'b1;
            mem_wd = q_b_q;
            wr_d   = wr_q + 1'b1;
          end
        end
        if (rd_q == TOP) state_d = (lc_d == '0) ? DONE : FILL;
      end
      FILL: begin
        mem_we  = 1'b1;
        wr_d    = wr_q + 1'b1;
        state_d = (wr_q == LAST) ? DONE : FILL;
      end
      default: state_d = IDLE;
    endcase
    busy_d = !(state_d == IDLE || state_d == DONE);
    done_d = state_d == DONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT;
      rd_q    <= '0;
      wr_q    <= '0;
      lc_q    <= '0;
      q_a_q   <= '0;
      q_b_q   <= '0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      lc_q    <= lc_d;
      q_a_q   <= q_a_d;
      q_b_q   <= q_b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  assign q_a           = q_a_q;
  assign q_b           = q_b_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign lines_cleared = lc_q;
endmodule

// File: tb/tb_grid_mem_lines.sv
// tb_grid_mem_lines: directed checks of the grid RAM ports, zero-fill and line-clear engine
module tb_grid_mem_lines;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] addr_a = '0;
  logic [9:0] data_a = '0;
  logic       we_a = 1'b0;
  logic [9:0] q_a;
  logic [4:0] addr_b = '0;
  logic [9:0] q_b;
  logic       clr_start = 1'b0;
  logic       busy;
  logic       done;
  logic [5:0] lines_cleared;
  int         n_chk = 0;
  int         n_err = 0;
  int         done_cnt = 0;
  int         n;
  logic [9:0] exp_rows [24];

  grid_mem_lines dut (
    .clk(clk), .rst_n(rst_n), .addr_a(addr_a), .data_a(data_a), .we_a(we_a), .q_a(q_a),
    .addr_b(addr_b), .q_b(q_b), .clr_start(clr_start), .busy(busy), .done(done),
    .lines_cleared(lines_cleared)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [9:0] d);
    addr_a = a;
    data_a = d;
    we_a   = 1'b1;
    tick();
    we_a   = 1'b0;
  endtask

  task automatic rd_all(input string tag);
    for (int r = 0; r < 24; r++) begin
      addr_b = 5'(r);
      tick();
      chk($sformatf("%s row%0d", tag, r), q_b, exp_rows[r]);
    end
  endtask

  task automatic clear_and_wait(output int cyc);
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    cyc = 1;
    while (!done && cyc < 200) begin
      tick();
      cyc++;
    end
  endtask

  task automatic count_init(output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (busy && cyc < 100);
  endtask

  initial begin
    tick();
    tick();
    chk("rst busy", busy, 1);
    chk("rst q_a", q_a, 0);
    chk("rst q_b", q_b, 0);
    chk("rst done", done, 0);
    chk("rst lines", lines_cleared, 0);
    rst_n = 1'b1;
    count_init(n);
    chk("init cycles", n, 24);
    foreach (exp_rows[r]) exp_rows[r] = '0;
    rd_all("init");
    chk("init no done", done_cnt, 0);

    wr(5'd0, 10'h3FF);
    chk("wr first q_a", q_a, 10'h3FF);
    addr_b = 5'd0; tick(); chk("rd b row0", q_b, 10'h3FF);
    addr_b = 5'd5; tick(); chk("rd b row5", q_b, 10'h000);
    wr(5'd24, 10'h3FF);
    chk("oob wr q_a", q_a, 10'h000);
    addr_a = 5'd24; addr_b = 5'd24; tick();
    chk("oob rd a", q_a, 10'h000);
    chk("oob rd b", q_b, 10'h000);

    wr(5'd3, 10'h0AA);
    addr_a = 5'd3; data_a = 10'h155; we_a = 1'b1; addr_b = 5'd3;
    tick();
    we_a = 1'b0;
    chk("coll q_a", q_a, 10'h155);
    chk("coll q_b old", q_b, 10'h0AA);
    tick();
    chk("coll q_b new", q_b, 10'h155);

    wr(5'd1, 10'h3FF);
    wr(5'd2, 10'h001);
    wr(5'd3, 10'h3FF);
    wr(5'd4, 10'h200);
    clear_and_wait(n);
    chk("clr3 latency", n, 29);
    chk("clr3 lines", lines_cleared, 3);
    chk("clr3 busy in done", busy, 0);
    foreach (exp_rows[r]) exp_rows[r] = '0;
    exp_rows[0] = 10'h001;
    exp_rows[1] = 10'h200;
    rd_all("clr3");
    chk("clr3 lines hold", lines_cleared, 3);

    for (int r = 0; r < 24; r++) wr(5'(r), 10'h3FF);
    done_cnt = 0;
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    n = 1;
    repeat (5) begin tick(); n++; end
    clr_start = 1'b1; tick(); n++; clr_start = 1'b0;
    while (!done && n < 200) begin tick(); n++; end
    chk("full latency", n, 50);
    chk("full lines", lines_cleared, 24);
    repeat (30) tick();
    chk("full single done", done_cnt, 1);
    chk("full idle", busy, 0);
    foreach (exp_rows[r]) exp_rows[r] = '0;
    rd_all("full");

    wr(5'd23, 10'h3FF);
    wr(5'd22, 10'h0F0);
    addr_a = 5'd0; data_a = 10'h3FF; we_a = 1'b1; clr_start = 1'b1;
    tick();
    we_a = 1'b0; clr_start = 1'b0;
    n = 1;
    while (!done && n < 200) begin tick(); n++; end
    chk("top latency", n, 28);
    chk("top lines", lines_cleared, 2);
    foreach (exp_rows[r]) exp_rows[r] = '0;
    exp_rows[21] = 10'h0F0;
    rd_all("top");

    wr(5'd7, 10'h3FF);
    wr(5'd0, 10'h123);
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    repeat (10) tick();
    done_cnt = 0;
    rst_n = 1'b0;
    #1;
    chk("abort busy", busy, 1);
    chk("abort lines", lines_cleared, 0);
    tick();
    rst_n = 1'b1;
    count_init(n);
    chk("abort init cycles", n, 24);
    chk("abort no done", done_cnt, 0);
    chk("abort lines after", lines_cleared, 0);
    foreach (exp_rows[r]) exp_rows[r] = '0;
    rd_all("abort");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/grid_mem_lines.md
Name: grid_mem_lines

Overview:
- Parametrised successor to the playfield grid RAM: one memory word per playfield row, one bit per cell (1 = occupied), row 0 = bottom.
- Port A is a synchronous read/write port and port B is a synchronous read-only port, both used by game logic and the display scanner.
- Adds two behaviours:
  - an automatic zero-fill after reset;
  - a line-clear engine that removes every full row and compacts the rows above it downward, reporting the number of lines removed.

Parameters:
- COLS, 10, row width in cells (word width).
- ROWS, 24, number of rows; must satisfy 2 <= ROWS <= 2**ADDR_W.
- ADDR_W, 5, row address width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- addr_a  in  ADDR_W  port A row address.
- data_a  in  COLS  port A write data.
- we_a  in  1  port A write enable.
- q_a  out  COLS  port A registered read data.
- addr_b  in  ADDR_W  port B row address.
- q_b  out  COLS  port B registered read data.
- clr_start  in  1  single-cycle request to run the line-clear engine.
- busy  out  1  high while zero-fill or line-clear is in progress.
- done  out  1  one-cycle pulse when a line-clear finishes.
- lines_cleared  out  ADDR_W+1  number of full rows removed by the last line-clear.

Behaviour:
- Reset (rst_n low, asynchronous):
  - q_a, q_b, done and lines_cleared go to 0.
  - busy goes to 1 and the state goes to INIT.
  - Memory contents are not reset directly; INIT overwrites them.
- INIT:
  - After rst_n deasserts, writes zero to rows 0..ROWS-1, one row per cycle (ROWS cycles), then moves to IDLE.
  - done is not pulsed on leaving INIT.
- IDLE, busy=0:
  - Port A: a write at the clk edge when we_a=1. Read latency is 1 cycle. Write-first: q_a shows data_a on the cycle after the write.
  - Port B: read latency is 1 cycle. On a same-cycle collision with a port A write to the same row, q_b returns the old data.
  - addr >= ROWS: writes are dropped and reads return 0.
- busy=1:
  - External we_a is ignored and q_a holds its last value.
  - q_b is undefined (the engine owns port B); addr_b is ignored.
  - clr_start is ignored.
- clr_start in IDLE:
  - Clears lines_cleared to 0 and enters SCAN with rd=0, wr=0.
- SCAN (pipelined, ROWS+1 cycles):
  - Each cycle the engine issues a read of row rd, then rd increments.
  - The data from the previous read is then evaluated:
    - if all COLS bits are 1: lines_cleared increments and wr holds;
    - otherwise: the row is written to wr and wr increments.
  - A write with wr==rd rewrites the same value (allowed).
  - When the final row has been evaluated, the engine enters FILL.
- FILL:
  - Writes zero to rows wr..ROWS-1, one per cycle, so it takes exactly lines_cleared cycles (0 cycles if none).
  - Then enters DONE.
- DONE:
  - done=1 for one cycle, busy=0 that cycle, then IDLE.
  - lines_cleared holds until the next accepted clr_start or reset.
- Total line-clear latency: clr_start accepted to done = ROWS+1+lines_cleared+1 cycles.
- Boundaries:
  - All rows full: lines_cleared=ROWS, and the whole grid ends up zero.
  - No full rows: contents are unchanged.
  - Full top row: it is removed and row ROWS-1 becomes zero.
  - clr_start and we_a in the same IDLE cycle: the write completes, and the engine starts on the next cycle with the write's data visible.
  - Reset mid-SCAN or mid-FILL: aborts immediately; INIT zero-fills and lines_cleared=0.

Test Plan:
- Reset then release -> busy=1 for exactly 24 cycles; afterwards a port B read of every row returns 0; no done pulse.
- Port A write 10'h3FF to row 0, then read rows 0 and 5 -> q_a=10'h3FF the cycle after the write; q_b of row 0 = 10'h3FF, q_b of row 5 = 0; write to row 24 is dropped and reading row 24 returns 0.
- Same-cycle port A write 10'h155 / port B read of row 3 (previous value 10'h0AA) -> q_a=10'h155 and q_b=10'h0AA; the next read gives 10'h155.
- Rows 0,1 = 10'h3FF, row 2 = 10'h001, row 3 = 10'h3FF, row 4 = 10'h200, clr_start ->
  - done after 24+1+3+1=29 cycles with lines_cleared=3;
  - row 0=10'h001, row 1=10'h200, rows 2..23 = 0.
- All 24 rows 10'h3FF, clr_start -> lines_cleared=24 and all rows 0; a second clr_start during busy is ignored.
- Reset asserted mid-SCAN -> busy stays 1 through INIT, lines_cleared=0, all rows 0 afterwards, no done pulse.
